// File: rtl/cf_spi_master_gen.sv
// cf_spi_master_gen: SPI master with TX/RX FIFOs, configurable frame width,
// LSB/MSB-first shifting, multiple chip selects with back-to-back CS hold and
// a sticky RX overflow flag.
// Optional build macro CF_SPI_LOOPBACK_EN adds a 'loopback' input that routes
// the internal mosi back into the receive shifter instead of miso.

// Show-ahead FIFO: dout always presents the oldest entry.
module cf_spi_master_gen_fifo #(
  parameter int DW  = 8,
  parameter int FAW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [FAW:0]  level
);
  localparam int DEPTH = 1 << FAW;

  logic [DW-1:0]  mem [DEPTH];
  logic [FAW-1:0] wptr_reg;
  logic [FAW-1:0] rptr_reg;
  logic [FAW:0]   count_reg;
  logic           pop_ok;
  logic           push_ok;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (FAW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rptr_reg];
  assign level   = count_reg;

  // Storage write; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr_reg] <= din;
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

module cf_spi_master_gen #(
  parameter int DW  = 8,
  parameter int FAW = 4,
  parameter int CDW = 8,
  parameter int NCS = 2,
  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic           CPOL,
  input  logic           CPHA,
  input  logic           lsb_first,
  input  logic [CDW-1:0] clk_divider,
  input  logic [CSW-1:0] cs_sel,
  input  logic           cs_hold,
  input  logic           wr,
  input  logic [DW-1:0]  datai,
  input  logic           rd,
  output logic [DW-1:0]  datao,
  input  logic           rx_en,
  input  logic           tx_flush,
  input  logic           rx_flush,
  input  logic [FAW:0]   tx_threshold,
  input  logic [FAW:0]   rx_threshold,
  output logic           tx_empty,
  output logic           tx_full,
  output logic           tx_level_below,
  output logic           rx_empty,
  output logic           rx_full,
  output logic           rx_level_above,
  output logic           rx_ovf,
  output logic [FAW:0]   tx_level,
  output logic [FAW:0]   rx_level,
  output logic           busy,
  output logic           done,
  output logic           sclk,
  output logic           mosi,
  input  logic           miso,
  output logic [NCS-1:0] csb
`ifdef CF_SPI_LOOPBACK_EN
  ,
  input  logic           loopback
`endif
);
  localparam int ECW = $clog2(2*DW) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t         state_reg;
  logic [CDW-1:0] cnt_reg, div_reg;
  logic [ECW-1:0] edge_reg;
  logic [DW-1:0]  tx_sh_reg, rx_sh_reg;
  logic           cpol_reg, cpha_reg, lsb_reg, hold_reg, rx_en_reg;
  logic [CSW-1:0] cs_reg;
  logic           sclk_reg, mosi_reg, busy_reg, done_reg, ovf_reg;
  logic [NCS-1:0] csb_reg, cs_dec;
  logic [DW-1:0]  tx_head, rx_next, rx_push_data;
  logic           tick, last_edge, do_sample, do_shift, rx_bit;
  logic           tx_pop, rx_push;

  cf_spi_master_gen_fifo #(.DW(DW), .FAW(FAW)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(wr), .din(datai),
    .pop(tx_pop), .dout(tx_head), .empty(tx_empty), .full(tx_full), .level(tx_level)
  );

  cf_spi_master_gen_fifo #(.DW(DW), .FAW(FAW)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .din(rx_push_data),
    .pop(rd), .dout(datao), .empty(rx_empty), .full(rx_full), .level(rx_level)
  );

  // One-hot decode of the requested chip select (out-of-range selects none).
  for (genvar gi = 0; gi < NCS; gi++) begin : g_cs_dec
    assign cs_dec[gi] = (cs_sel == CSW'(gi));
  end

`ifdef CF_SPI_LOOPBACK_EN
  assign rx_bit = loopback ? mosi_reg : miso;
`else
  assign rx_bit = miso;
`endif

  // edge_reg is the 0-based index of the upcoming SCLK edge; even index = odd edge.
  assign tick         = (cnt_reg == '0);
  assign last_edge    = (edge_reg == ECW'(2*DW-1));
  assign do_sample    = cpha_reg ? edge_reg[0] : ~edge_reg[0];
  // In CPHA=1 the first bit is already on mosi, so the first leading edge does not advance.
  assign do_shift     = !last_edge &&
                        (cpha_reg ? (!edge_reg[0] && (edge_reg != '0)) : edge_reg[0]);
  assign rx_next      = lsb_reg ? {rx_bit, rx_sh_reg[DW-1:1]} : {rx_sh_reg[DW-2:0], rx_bit};
  assign rx_push_data = do_sample ? rx_next : rx_sh_reg;
  assign rx_push      = (state_reg == SHIFT) && tick && last_edge && rx_en_reg;
  assign tx_pop       = enable && !tx_empty && !tx_flush &&
                        ((state_reg == IDLE) ||
                         ((state_reg == GAP) && tick && hold_reg && (cs_sel == cs_reg)));

  // Frame sequencer: IDLE -> SETUP -> SHIFT -> GAP, with a back-to-back path GAP -> SETUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      div_reg   <= '0;
      edge_reg  <= '0;
      tx_sh_reg <= '0;
      rx_sh_reg <= '0;
      cpol_reg  <= 1'b0;
      cpha_reg  <= 1'b0;
      lsb_reg   <= 1'b0;
      hold_reg  <= 1'b0;
      rx_en_reg <= 1'b0;
      cs_reg    <= '0;
      sclk_reg  <= CPOL;
      mosi_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      csb_reg   <= '1;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          sclk_reg <= CPOL;
          csb_reg  <= '1;
        end
        SETUP: begin
          // Counter is left at zero so the first SCLK edge follows one cycle later.
          if (tick) state_reg <= SHIFT;
          else      cnt_reg   <= cnt_reg - 1'b1;
        end
        SHIFT: begin
          if (tick) begin
            cnt_reg  <= div_reg;
            sclk_reg <= ~sclk_reg;
            edge_reg <= edge_reg + 1'b1;
            if (do_sample) rx_sh_reg <= rx_next;
            if (do_shift) begin
              if (lsb_reg) begin
                tx_sh_reg <= {1'b0, tx_sh_reg[DW-1:1]};
                mosi_reg  <= tx_sh_reg[1];
              end else begin
                tx_sh_reg <= {tx_sh_reg[DW-2:0], 1'b0};
                mosi_reg  <= tx_sh_reg[DW-2];
              end
            end
            if (last_edge) begin
              sclk_reg  <= cpol_reg;
              done_reg  <= 1'b1;
              edge_reg  <= '0;
              state_reg <= GAP;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state_reg <= IDLE;
            csb_reg   <= '1;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Frame load (from IDLE or a held GAP) overrides the per-state updates above.
      if (tx_pop) begin
        tx_sh_reg <= tx_head;
        rx_sh_reg <= '0;
        mosi_reg  <= lsb_first ? tx_head[0] : tx_head[DW-1];
        cs_reg    <= cs_sel;
        csb_reg   <= ~cs_dec;
        cpol_reg  <= CPOL;
        cpha_reg  <= CPHA;
        lsb_reg   <= lsb_first;
        hold_reg  <= cs_hold;
        rx_en_reg <= rx_en;
        div_reg   <= clk_divider;
        cnt_reg   <= clk_divider;
        edge_reg  <= '0;
        sclk_reg  <= CPOL;
        busy_reg  <= 1'b1;
        state_reg <= SETUP;
      end
    end
  end

  // Sticky overflow: a finished frame found the RX FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (rst || rx_flush) ovf_reg <= 1'b0;
    else if (rx_push && rx_full && !(rd && !rx_empty)) ovf_reg <= 1'b1;
  end

  assign tx_level_below = (tx_level < tx_threshold);
  assign rx_level_above = (rx_level > rx_threshold);
  assign rx_ovf         = ovf_reg;
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign sclk           = sclk_reg;
  assign mosi           = mosi_reg;
  assign csb            = csb_reg;
endmodule
